// File: rtl/fft_seq_pkg.sv
// Shared definitions for the FFT stage sequencer: FSM state codes and address helpers.
// Optional build macro used by the sequencer: FFT_SEQ_BITREV_EN.
package fft_seq_pkg;

    localparam int SEQ_MAXW = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] SWAP  = 2'd3;

    // Reverse the low l bits of val; bits at or above l come out as zero.
    function automatic logic [SEQ_MAXW-1:0] bit_reverse(input logic [SEQ_MAXW-1:0] val,
                                                        input int l);
        logic [SEQ_MAXW-1:0] r;
        r = {SEQ_MAXW{1'b0}};
        for (int i = 0; i < SEQ_MAXW; i++) begin
            if (i < l) begin
                r[i] = val[l-1-i];
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    // Twiddle index: butterfly index with its low clr bits cleared.
    function automatic logic [SEQ_MAXW-1:0] tw_mask(input logic [SEQ_MAXW-1:0] k,
                                                    input int unsigned clr);
        logic [SEQ_MAXW-1:0] m;
        m = {SEQ_MAXW{1'b1}} << clr;
        return k & m;
    endfunction

endpackage

// File: rtl/fft_stage_seq_if.sv
// Control bundle between the FFT stage sequencer, its requester and the ping-pong memory controller.
interface fft_stage_seq_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int STAGE_W    = 4
);
    logic                  start;
    logic [STAGE_W-1:0]    log2n;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  mem_sel;
    logic                  read_en;
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [STAGE_W-1:0]    stage_idx;
    logic                  bfly_in_valid;
    logic [ADDR_WIDTH-2:0] tw_addr;

    modport master (
        input  start, log2n,
        output busy, done, err, mem_sel, read_en, write_en, read_addr, write_addr,
               stage_idx, bfly_in_valid, tw_addr
    );

    modport slave (
        output start, log2n,
        input  busy, done, err, mem_sel, read_en, write_en, read_addr, write_addr,
               stage_idx, bfly_in_valid, tw_addr
    );
endinterface

// File: rtl/fft_addr_gen.sv
// Combinational constant-geometry read/twiddle address map for one read index.
// Pairs index k with k+N/2 on consecutive cycles; twiddle granularity coarsens on early passes.
module fft_addr_gen
    import fft_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int STAGE_W    = 4
) (
    input  logic [ADDR_WIDTH:0]   rcnt,
    input  logic [STAGE_W-1:0]    l,
    input  logic [STAGE_W-1:0]    stage,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic [ADDR_WIDTH-2:0] tw_addr
);
    logic [ADDR_WIDTH-2:0] k_s;
    logic [ADDR_WIDTH-1:0] half_s;
    logic [STAGE_W-1:0]    clr_s;
    logic [SEQ_MAXW-1:0]   tw_full_s;
    logic                  unused_s;

    assign k_s       = rcnt[ADDR_WIDTH-1:1];
    assign half_s    = ADDR_WIDTH'(1) << (l - STAGE_W'(1));
    assign clr_s     = l - STAGE_W'(1) - stage;
    assign tw_full_s = tw_mask(SEQ_MAXW'(k_s), 32'(clr_s));
    assign read_addr = {1'b0, k_s} + (rcnt[0] ? half_s : {ADDR_WIDTH{1'b0}});
    assign tw_addr   = tw_full_s[ADDR_WIDTH-2:0];
    assign unused_s  = ^{tw_full_s, rcnt[ADDR_WIDTH]};
endmodule

// File: rtl/fft_stage_seq.sv
// Pass sequencer for a ping-pong radix-2 FFT: N reads per pass, writes trail by PIPE_LAT.
// Define FFT_SEQ_BITREV_EN to store the final pass in natural (bit-reversed address) order.
module fft_stage_seq
    import fft_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int STAGE_W    = 4,
    parameter int PIPE_LAT   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fft_stage_seq_if.master bus
);
    logic [1:0]            state_r, state_nx;
    logic [STAGE_W-1:0]    l_r, l_nx;
    logic [STAGE_W-1:0]    stage_r, stage_nx;
    logic [ADDR_WIDTH:0]   nlast_r, nlast_nx;
    logic [ADDR_WIDTH:0]   rcnt_r, rcnt_nx;
    logic [ADDR_WIDTH:0]   wcnt_r, wcnt_nx;
    logic [PIPE_LAT-1:0]   sh_r, sh_nx;
    logic                  busy_r, busy_nx;
    logic                  done_r, done_nx;
    logic                  err_r, err_nx;
    logic                  mem_sel_r, mem_sel_nx;
    logic                  read_en_r;
    logic                  write_en_r, write_en_nx;
    logic                  valid_r, valid_nx;
    logic                  wr_nx;
    logic [ADDR_WIDTH-1:0] read_addr_r, read_addr_nx;
    logic [ADDR_WIDTH-1:0] write_addr_r, write_addr_nx;
    logic [ADDR_WIDTH-2:0] tw_addr_r, tw_addr_nx;
    logic [ADDR_WIDTH-1:0] ag_read_addr_s;
    logic [ADDR_WIDTH-2:0] ag_tw_addr_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic                  legal_s;
    logic                  last_pass_s;

    assign legal_s     = (bus.log2n != {STAGE_W{1'b0}}) && (bus.log2n <= STAGE_W'(ADDR_WIDTH));
    assign last_pass_s = (stage_r == (l_r - STAGE_W'(1)));

    // Addresses are generated for the next cycle's read so they can be registered.
    fft_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STAGE_W    (STAGE_W)
    ) u_addr_gen (
        .rcnt      (rcnt_nx),
        .l         (l_nx),
        .stage     (stage_nx),
        .read_addr (ag_read_addr_s),
        .tw_addr   (ag_tw_addr_s)
    );

    // Pass-level FSM: next state, counters and read-side strobes.
    always_comb begin
        state_nx   = state_r;
        l_nx       = l_r;
        nlast_nx   = nlast_r;
        rcnt_nx    = rcnt_r;
        stage_nx   = stage_r;
        mem_sel_nx = mem_sel_r;
        busy_nx    = busy_r;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        valid_nx   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start && legal_s) begin
                    state_nx   = READ;
                    l_nx       = bus.log2n;
                    nlast_nx   = ((ADDR_WIDTH+1)'(1) << bus.log2n) - (ADDR_WIDTH+1)'(1);
                    rcnt_nx    = {(ADDR_WIDTH+1){1'b0}};
                    stage_nx   = {STAGE_W{1'b0}};
                    mem_sel_nx = 1'b1;
                    busy_nx    = 1'b1;
                    valid_nx   = 1'b1;
                end else if (bus.start) begin
                    err_nx = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            READ: begin
                if (rcnt_r == nlast_r) begin
                    state_nx = DRAIN;
                end else begin
                    rcnt_nx  = rcnt_r + (ADDR_WIDTH+1)'(1);
                    valid_nx = 1'b1;
                end
            end
            DRAIN: begin
                // Leave once the final write of the pass is on the bus.
                if (!write_en_r && (wcnt_r == nlast_r)) begin
                    state_nx = SWAP;
                end else begin
                    state_nx = DRAIN;
                end
            end
            SWAP: begin
                if (last_pass_s) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                end else begin
                    state_nx   = READ;
                    stage_nx   = stage_r + STAGE_W'(1);
                    mem_sel_nx = ~mem_sel_r;
                    rcnt_nx    = {(ADDR_WIDTH+1){1'b0}};
                    valid_nx   = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // Write side: a write issues PIPE_LAT cycles after each read.
    always_comb begin
        wr_nx = sh_r[PIPE_LAT-1];
        sh_nx = (sh_r << 1) | PIPE_LAT'(valid_nx);
        if (wr_nx) begin
            wcnt_nx = write_en_r ? {(ADDR_WIDTH+1){1'b0}} : (wcnt_r + (ADDR_WIDTH+1)'(1));
        end else begin
            wcnt_nx = wcnt_r;
        end
        write_en_nx = ~wr_nx;
    end

`ifdef FFT_SEQ_BITREV_EN
    logic [SEQ_MAXW-1:0] rev_s;
    logic                unused_rev_s;
    assign rev_s        = bit_reverse(SEQ_MAXW'(wcnt_nx[ADDR_WIDTH-1:0]), 32'(l_r));
    assign unused_rev_s = ^rev_s;
    assign wr_addr_s    = last_pass_s ? rev_s[ADDR_WIDTH-1:0] : wcnt_nx[ADDR_WIDTH-1:0];
`else
    assign wr_addr_s    = wcnt_nx[ADDR_WIDTH-1:0];
`endif

    // Address outputs hold their last value when idle.
    always_comb begin
        if (valid_nx) begin
            read_addr_nx = ag_read_addr_s;
            tw_addr_nx   = ag_tw_addr_s;
        end else begin
            read_addr_nx = read_addr_r;
            tw_addr_nx   = tw_addr_r;
        end
        if (wr_nx) begin
            write_addr_nx = wr_addr_s;
        end else begin
            write_addr_nx = write_addr_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            l_r          <= {STAGE_W{1'b0}};
            stage_r      <= {STAGE_W{1'b0}};
            nlast_r      <= {(ADDR_WIDTH+1){1'b0}};
            rcnt_r       <= {(ADDR_WIDTH+1){1'b0}};
            wcnt_r       <= {(ADDR_WIDTH+1){1'b0}};
            sh_r         <= {PIPE_LAT{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            mem_sel_r    <= 1'b1;
            read_en_r    <= 1'b1;
            write_en_r   <= 1'b1;
            valid_r      <= 1'b0;
            read_addr_r  <= {ADDR_WIDTH{1'b0}};
            write_addr_r <= {ADDR_WIDTH{1'b0}};
            tw_addr_r    <= {(ADDR_WIDTH-1){1'b0}};
        end else begin
            state_r      <= state_nx;
            l_r          <= l_nx;
            stage_r      <= stage_nx;
            nlast_r      <= nlast_nx;
            rcnt_r       <= rcnt_nx;
            wcnt_r       <= wcnt_nx;
            sh_r         <= sh_nx;
            busy_r       <= busy_nx;
            done_r       <= done_nx;
            err_r        <= err_nx;
            mem_sel_r    <= mem_sel_nx;
            read_en_r    <= 1'b1;
            write_en_r   <= write_en_nx;
            valid_r      <= valid_nx;
            read_addr_r  <= read_addr_nx;
            write_addr_r <= write_addr_nx;
            tw_addr_r    <= tw_addr_nx;
        end
    end

    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.err           = err_r;
    assign bus.mem_sel       = mem_sel_r;
    assign bus.read_en       = read_en_r;
    assign bus.write_en      = write_en_r;
    assign bus.read_addr     = read_addr_r;
    assign bus.write_addr    = write_addr_r;
    assign bus.stage_idx     = stage_r;
    assign bus.bfly_in_valid = valid_r;
    assign bus.tw_addr       = tw_addr_r;
endmodule

// File: tb/tb_fft_stage_seq.sv
// Scoreboard bench for fft_stage_seq: expected read/write/done events queued at start, checked on output.
module tb_fft_stage_seq;
    localparam int AW = 12;
    localparam int SW = 4;
    localparam int PL = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fft_stage_seq_if #(.ADDR_WIDTH(AW), .STAGE_W(SW)) bus ();

    fft_stage_seq #(.ADDR_WIDTH(AW), .STAGE_W(SW), .PIPE_LAT(PL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int tw;
        int cyc;
        int msel;
        int stg;
    } ev_t;

    typedef struct {
        logic [SW-1:0] log2n;
        logic          exp_err;
        logic          exp_busy;
    } vec_t;

    ev_t rd_q[$];
    ev_t wr_q[$];
    int  exp_done_cyc;
    bit  done_seen;
    time t0;
    ev_t mon_e;
    int  mon_c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int rev_bits(input int v, input int l);
        int r;
        r = 0;
        for (int i = 0; i < l; i++) r = r | (((v >> i) & 1) << (l - 1 - i));
        return r;
    endfunction

    function automatic void push_expected(input int l);
        int n;
        int plen;
        ev_t e;
        n = 1 << l;
        plen = n + PL + 1;
        for (int p = 0; p < l; p++) begin
            for (int r = 0; r < n; r++) begin
                e.addr = (r >> 1) + (((r & 1) != 0) ? (n / 2) : 0);
                e.tw   = (r >> 1) & ~((1 << (l - 1 - p)) - 1);
                e.cyc  = p * plen + r;
                e.msel = ((p & 1) == 0) ? 1 : 0;
                e.stg  = p;
                rd_q.push_back(e);
            end
            for (int w = 0; w < n; w++) begin
                e.addr = w;
`ifdef FFT_SEQ_BITREV_EN
                if (p == l - 1) e.addr = rev_bits(w, l);
`endif
                e.tw   = 0;
                e.cyc  = p * plen + PL + w;
                e.msel = ((p & 1) == 0) ? 1 : 0;
                e.stg  = p;
                wr_q.push_back(e);
            end
        end
        exp_done_cyc = l * plen;
    endfunction

    // Output monitor: every read, write and done is matched against the queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_c = int'(($time - t0 - 5) / 10);
            if (bus.bfly_in_valid) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = rd_q.pop_front();
                    chk("rd_addr", 32'(bus.read_addr), mon_e.addr);
                    chk("tw_addr", 32'(bus.tw_addr), mon_e.tw);
                    chk("rd_cycle", mon_c, mon_e.cyc);
                    chk("rd_mem_sel", 32'(bus.mem_sel), mon_e.msel);
                    chk("rd_stage", 32'(bus.stage_idx), mon_e.stg);
                    chk("rd_busy", 32'(bus.busy), 32'd1);
                end
            end
            if (!bus.write_en) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = wr_q.pop_front();
                    chk("wr_addr", 32'(bus.write_addr), mon_e.addr);
                    chk("wr_cycle", mon_c, mon_e.cyc);
                    chk("wr_mem_sel", 32'(bus.mem_sel), mon_e.msel);
                end
            end
            if (bus.done) begin
                chk("done_cycle", mon_c, exp_done_cyc);
                chk("done_busy", 32'(bus.busy), 32'd0);
                chk("done_rd_empty", rd_q.size(), 32'd0);
                chk("done_wr_empty", wr_q.size(), 32'd0);
                done_seen = 1'b1;
            end
        end
    end

    task automatic chk_reset_vals();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_mem_sel", 32'(bus.mem_sel), 32'd1);
        chk("rst_read_en", 32'(bus.read_en), 32'd1);
        chk("rst_write_en", 32'(bus.write_en), 32'd1);
        chk("rst_read_addr", 32'(bus.read_addr), 32'd0);
        chk("rst_write_addr", 32'(bus.write_addr), 32'd0);
        chk("rst_stage_idx", 32'(bus.stage_idx), 32'd0);
        chk("rst_valid", 32'(bus.bfly_in_valid), 32'd0);
        chk("rst_tw_addr", 32'(bus.tw_addr), 32'd0);
    endtask

    task automatic do_start(input logic [SW-1:0] l, input logic legal, output logic err_o,
                            output logic busy_o);
        @(negedge clk);
        bus.start = 1'b1;
        bus.log2n = l;
        done_seen = 1'b0;
        @(posedge clk);
        t0 = $time;
        if (legal) push_expected(int'(l));
        @(negedge clk);
        bus.start = 1'b0;
        err_o  = bus.err;
        busy_o = bus.busy;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done_seen && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done_seen), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(bus.done), 32'd0);
    endtask

    initial begin
        vec_t tbl[6];
        logic e_s;
        logic b_s;
        logic legal;
        checks    = 0;
        failures  = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.log2n = '0;
        t0        = 0;
        done_seen = 1'b0;
        exp_done_cyc = 0;

        tbl[0] = '{log2n: 4'd0,  exp_err: 1'b1, exp_busy: 1'b0};
        tbl[1] = '{log2n: 4'd13, exp_err: 1'b1, exp_busy: 1'b0};
        tbl[2] = '{log2n: 4'd1,  exp_err: 1'b0, exp_busy: 1'b1};
        tbl[3] = '{log2n: 4'd3,  exp_err: 1'b0, exp_busy: 1'b1};
        tbl[4] = '{log2n: 4'd15, exp_err: 1'b1, exp_busy: 1'b0};
        tbl[5] = '{log2n: 4'd2,  exp_err: 1'b0, exp_busy: 1'b1};

        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            legal = ~tbl[i].exp_err;
            do_start(tbl[i].log2n, legal, e_s, b_s);
            chk("start_err", 32'(e_s), 32'(tbl[i].exp_err));
            chk("start_busy", 32'(b_s), 32'(tbl[i].exp_busy));
            if (legal) begin
                wait_done(2000);
            end else begin
                @(negedge clk);
                chk("err_one_cycle", 32'(bus.err), 32'd0);
                chk("err_busy_low", 32'(bus.busy), 32'd0);
            end
        end

        // A second start during pass 1 must be ignored without err.
        do_start(4'd3, 1'b1, e_s, b_s);
        repeat (15) @(negedge clk);
        bus.start = 1'b1;
        bus.log2n = 4'd2;
        @(negedge clk);
        chk("busy_start_err", 32'(bus.err), 32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        chk("busy_start_err2", 32'(bus.err), 32'd0);
        wait_done(200);

        // Asynchronous reset in the middle of pass 1, then a fresh transform.
        do_start(4'd3, 1'b1, e_s, b_s);
        repeat (18) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        rd_q.delete();
        wr_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        chk("post_rst_write_en", 32'(bus.write_en), 32'd1);
        do_start(4'd3, 1'b1, e_s, b_s);
        chk("restart_busy", 32'(b_s), 32'd1);
        wait_done(200);

        // Largest transform: counters must span 4096 without wrapping.
        do_start(4'd12, 1'b1, e_s, b_s);
        chk("big_busy", 32'(b_s), 32'd1);
        wait_done(50000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
